// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and buffers returns in a small FIFO for decode.
// Optional build macro IF_PERF_CNT_EN adds the fetch_cnt / bubble_cnt performance counter ports.
module if_fetch_stage #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [15:0] RESET_PC   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_re,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] redirect_addr,
   output logic [15:0] instr,
   output logic [15:0] pc_out,
   output logic        instr_valid,
   output logic        halted
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0] fetch_cnt,
   output logic [15:0] bubble_cnt
`endif
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [3:0]  HLT_OP = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc_inc;
   } fetch_entry_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] req_addr_q, req_addr_d;
   logic              squash_q, squash_d;
   logic              halt_seen_q, halt_seen_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   fetch_entry_t      fifo_q [FIFO_DEPTH];

   logic              rdy_ok;
   logic              push;
   logic              pop;
   logic              issue;
   logic              push_is_hlt;
   logic [CNT_W-1:0]  occ_next;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;

   assign head        = fifo_q[rd_ptr_q];
   assign push_entry  = {imem_rdata, req_addr_q + 16'd1};
   assign push_is_hlt = (imem_rdata[15:12] == HLT_OP);

   // State, PC and FIFO bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         req_addr_q  <= '0;
         squash_q    <= 1'b0;
         halt_seen_q <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         squash_q    <= squash_d;
         halt_seen_q <= halt_seen_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[wr_ptr_q] <= push_entry;
      end
   end

   // Next-state: flush wins over push/pop/issue; HALTED is terminal until reset
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      squash_d    = squash_q;
      halt_seen_d = halt_seen_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      rdy_ok      = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      issue       = 1'b0;
      occ_next    = count_q;

      case (state_q)
         ST_RUN, ST_WAIT: begin
            rdy_ok = (state_q == ST_WAIT) && imem_rdy;
            if (flush) begin
               pc_d        = redirect_addr;
               halt_seen_d = 1'b0;
               rd_ptr_d    = '0;
               wr_ptr_d    = '0;
               count_d     = '0;
               // A request still in flight is retired later and its data dropped
               if ((state_q == ST_WAIT) && !imem_rdy) begin
                  state_d  = ST_WAIT;
                  squash_d = 1'b1;
               end else begin
                  state_d  = ST_RUN;
                  squash_d = 1'b0;
               end
            end else begin
               push     = rdy_ok && !squash_q;
               pop      = (count_q != '0) && !stall;
               occ_next = count_q + CNT_W'(push) - CNT_W'(pop);
               issue    = ((state_q == ST_RUN) || rdy_ok) &&
                          !halt_seen_q && !(push && push_is_hlt) &&
                          (occ_next < CNT_W'(FIFO_DEPTH));
               count_d  = occ_next;

               if (push) begin
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  if (push_is_hlt) begin
                     halt_seen_d = 1'b1;
                  end
               end
               if (pop) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end

               if (issue) begin
                  state_d    = ST_WAIT;
                  req_addr_d = pc_q;
                  pc_d       = pc_q + 16'd1;
                  squash_d   = 1'b0;
               end else if (rdy_ok) begin
                  state_d  = ST_RUN;
                  squash_d = 1'b0;
               end

               if (pop && (head.instr[15:12] == HLT_OP)) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Request is combinational so a 1-cycle memory sustains one fetch per cycle
   assign imem_re     = rst_n && issue;
   assign imem_addr   = imem_re ? pc_q : '0;
   assign instr_valid = (count_q != '0) && (state_q != ST_HALTED);
   assign instr       = instr_valid ? head.instr  : '0;
   assign pc_out      = instr_valid ? head.pc_inc : '0;
   assign halted      = (state_q == ST_HALTED);

`ifdef IF_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] bubble_cnt_q;

   // Saturating counters, frozen once halted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (state_q != ST_HALTED) begin
         if (push && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         end
         if (!instr_valid && !stall && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
         end
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
